// File: rtl/qkv_proj_sequencer_if.sv
// Bus between the attention controller / MAC datapath and the QKV sequencer.
// Carries the start/done handshake, the MAC issue strobes and addresses,
// and the result write strobes. Clock and reset are plain ports.
interface qkv_proj_sequencer_if #(
  parameter int L = 8,
  parameter int N = 1,
  parameter int E = 8
);
  localparam int XW = (L * N * E > 1) ? $clog2(L * N * E) : 1;
  localparam int WW = (E * E > 1) ? $clog2(E * E) : 1;

  logic          start;
  logic [2:0]    mat_en;
  logic          stall;
  logic          busy;
  logic          done;
  logic          mac_valid;
  logic          mac_first;
  logic          mac_last;
  logic [1:0]    w_sel;
  logic [XW-1:0] x_addr;
  logic [WW-1:0] w_addr;
  logic          wr_en;
  logic [1:0]    wr_sel;
  logic [XW-1:0] wr_addr;

  modport master (
    output start, mat_en, stall,
    input  busy, done, mac_valid, mac_first, mac_last, w_sel, x_addr, w_addr,
    input  wr_en, wr_sel, wr_addr
  );

  modport slave (
    input  start, mat_en, stall,
    output busy, done, mac_valid, mac_first, mac_last, w_sel, x_addr, w_addr,
    output wr_en, wr_sel, wr_addr
  );
endinterface

// File: rtl/qkv_proj_sequencer.sv
// QKV projection sequencer: walks (matrix, token, output dim, dot index),
// drives one shared MAC with x/weight addresses and first/last strobes, and
// delays each mac_last issue by MAC_LAT cycles to produce result writes.
module qkv_proj_sequencer #(
  parameter int L       = 8,
  parameter int N       = 1,
  parameter int E       = 8,
  parameter int MAC_LAT = 3
) (
  input logic clk,
  input logic rst,
  qkv_proj_sequencer_if.slave bus
);
  localparam int          LN  = L * N;
  localparam int          XW  = (LN * E > 1) ? $clog2(LN * E) : 1;
  localparam int          WW  = (E * E > 1) ? $clog2(E * E) : 1;
  localparam int          TW  = (LN > 1) ? $clog2(LN) : 1;
  localparam int          KW  = (E > 1) ? $clog2(E) : 1;
  localparam int unsigned LAT = MAC_LAT;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [2:0]    en_q, en_d;
  logic [1:0]    mat_q, mat_d;
  logic [TW-1:0] tok_q, tok_d;
  logic [KW-1:0] d_q, d_d;
  logic [KW-1:0] k_q, k_d;

  logic          pv_q [LAT];
  logic [1:0]    ps_q [LAT];
  logic [XW-1:0] pa_q [LAT];

  logic          issuing, mac_valid, mac_last;
  logic          nxt_found, pending;
  logic [1:0]    nxt_mat, fst_mat;
  logic [XW-1:0] res_addr;

  assign issuing   = (state_q == S_ISSUE);
  assign mac_valid = issuing & ~bus.stall;
  assign mac_last  = mac_valid & (k_q == KW'(E - 1));
  assign res_addr  = XW'(tok_q) * XW'(E) + XW'(d_q);

  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = (state_q == S_DONE);
  assign bus.mac_valid = mac_valid;
  assign bus.mac_first = mac_valid & (k_q == '0);
  assign bus.mac_last  = mac_last;
  assign bus.w_sel     = issuing ? mat_q : '0;
  assign bus.x_addr    = issuing ? XW'(tok_q) * XW'(E) + XW'(k_q) : '0;
  assign bus.w_addr    = issuing ? WW'(d_q) * WW'(E) + WW'(k_q) : '0;
  assign bus.wr_en     = pv_q[LAT-1];
  assign bus.wr_sel    = pv_q[LAT-1] ? ps_q[LAT-1] : '0;
  assign bus.wr_addr   = pv_q[LAT-1] ? pa_q[LAT-1] : '0;

  // State and loop counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      en_q    <= '0;
      mat_q   <= '0;
      tok_q   <= '0;
      d_q     <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      mat_q   <= mat_d;
      tok_q   <= tok_d;
      d_q     <= d_d;
      k_q     <= k_d;
    end
  end

  // Result delay line: shifts every cycle, independent of stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < LAT; i++) begin
        pv_q[i] <= 1'b0;
        ps_q[i] <= '0;
        pa_q[i] <= '0;
      end
    end else begin
      pv_q[0] <= mac_last;
      ps_q[0] <= mat_q;
      pa_q[0] <= res_addr;
      for (int unsigned i = 1; i < LAT; i++) begin
        pv_q[i] <= pv_q[i-1];
        ps_q[i] <= ps_q[i-1];
        pa_q[i] <= pa_q[i-1];
      end
    end
  end

  // Matrix selection and drain detection helpers.
  always_comb begin
    nxt_found = 1'b0;
    nxt_mat   = '0;
    fst_mat   = '0;
    pending   = 1'b0;
    for (int unsigned j = 0; j < 3; j++) begin
      if (!nxt_found && j > 32'(mat_q) && en_q[j]) begin
        nxt_found = 1'b1;
        nxt_mat   = 2'(j);
      end
    end
    for (int unsigned j = 3; j > 0; j--) begin
      if (bus.mat_en[j-1]) fst_mat = 2'(j - 1);
    end
    // Stages that will still hold a result after this cycle's shift.
    for (int unsigned i = 0; i + 1 < LAT; i++) begin
      pending = pending | pv_q[i];
    end
  end

  // Next-state and counter advance, k innermost, then d, tok, matrix.
  always_comb begin
    state_d = state_q;
    en_d    = en_q;
    mat_d   = mat_q;
    tok_d   = tok_q;
    d_d     = d_q;
    k_d     = k_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          en_d  = bus.mat_en;
          tok_d = '0;
          d_d   = '0;
          k_d   = '0;
          mat_d = fst_mat;
          // An empty mask still passes through DRAIN so done lands two cycles after start.
          state_d = (bus.mat_en == '0) ? S_DRAIN : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!bus.stall) begin
          k_d = k_q + KW'(1);
          if (k_q == KW'(E - 1)) begin
            k_d = '0;
            d_d = d_q + KW'(1);
            if (d_q == KW'(E - 1)) begin
              d_d   = '0;
              tok_d = tok_q + TW'(1);
              if (tok_q == TW'(LN - 1)) begin
                tok_d = '0;
                if (nxt_found) mat_d = nxt_mat;
                else           state_d = S_DRAIN;
              end
            end
          end
        end
      end
      S_DRAIN: begin
        if (!pending) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_qkv_proj_sequencer.sv
// Scoreboard bench for qkv_proj_sequencer: a reference model enumerates the
// expected issue/write streams with their cycle numbers from the stall
// pattern; a negedge monitor pops and compares whatever the DUT presents.
module tb_qkv_proj_sequencer;
  localparam int L = 8, N = 1, E = 8, MAC_LAT = 3;
  localparam int LN   = L * N;
  localparam int XW   = $clog2(L * N * E);
  localparam int WW   = $clog2(E * E);
  localparam int MAXC = 4096;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  qkv_proj_sequencer_if #(.L(L), .N(N), .E(E)) bus ();

  qkv_proj_sequencer #(.L(L), .N(N), .E(E), .MAC_LAT(MAC_LAT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  typedef struct {
    logic [1:0]    sel;
    logic [XW-1:0] x;
    logic [WW-1:0] w;
    logic          first;
    logic          last;
    int            cyc;
  } iss_t;

  typedef struct {
    logic [1:0]    sel;
    logic [XW-1:0] a;
    int            cyc;
  } wr_t;

  iss_t expI[$];
  wr_t  expW[$];
  int   cyc = 0;
  int   t0 = 0;
  bit   active = 1'b0;
  int   exp_done = -1;
  int   rst_rel = -1;
  bit   got_done = 1'b0;
  bit   stall_pat [MAXC];
  int   n_chk = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (rel cycle %0d)", name, act, exp, cyc - t0);
    end
  endtask

  // Monitor: compares every DUT output event against the scoreboard queues.
  always @(negedge clk) begin
    int   rel;
    bit   exp_busy;
    iss_t ei;
    wr_t  ew;
    if (active) begin
      rel = cyc - t0;
      if (rst_rel >= 0 && rel == rst_rel + 1)
        check("post_reset_zero",
              64'({bus.busy, bus.done, bus.mac_valid, bus.mac_first, bus.mac_last, bus.w_sel,
                   bus.x_addr, bus.w_addr, bus.wr_en, bus.wr_sel, bus.wr_addr}), 64'(0));
      if (exp_done >= 0) exp_busy = (rel >= 1) && (rel <= exp_done);
      else               exp_busy = (rel >= 1) && (rel <= rst_rel);
      check("busy", 64'(bus.busy), 64'(exp_busy));
      if (bus.mac_valid) begin
        if (expI.size() == 0) check("unexpected_issue", 64'(1), 64'(0));
        else begin
          ei = expI.pop_front();
          check("issue",
                64'({bus.w_sel, bus.x_addr, bus.w_addr, bus.mac_first, bus.mac_last, rel}),
                64'({ei.sel, ei.x, ei.w, ei.first, ei.last, ei.cyc}));
        end
      end
      if (bus.wr_en) begin
        if (expW.size() == 0) check("unexpected_wr", 64'(1), 64'(0));
        else begin
          ew = expW.pop_front();
          check("write", 64'({bus.wr_sel, bus.wr_addr, rel}), 64'({ew.sel, ew.a, ew.cyc}));
        end
      end
      if (bus.done) begin
        got_done = 1'b1;
        check("done_cycle", 64'(rel), 64'(exp_done));
      end
    end
  end

  // One run: model the expected streams, then drive start/stall/rst by relative cycle.
  task automatic run(input logic [2:0] men, input int stall_pct, input int st_lo, input int st_hi,
                     input int restart_at, input int reset_at);
    int   c, last_c, m_cnt, rel;
    iss_t ei;
    wr_t  ew;
    for (int i = 0; i < MAXC; i++)
      stall_pat[i] = ($urandom_range(99) < stall_pct) || (i >= st_lo && i <= st_hi);
    expI.delete();
    expW.delete();
    c = 1; last_c = 0; m_cnt = 0;
    for (int m = 0; m < 3; m++) begin
      if (men[m]) begin
        m_cnt++;
        for (int tk = 0; tk < LN; tk++)
          for (int d = 0; d < E; d++)
            for (int k = 0; k < E; k++) begin
              while (c < MAXC && stall_pat[c]) c++;
              ei.sel = 2'(m); ei.x = XW'(tk * E + k); ei.w = WW'(d * E + k);
              ei.first = (k == 0); ei.last = (k == E - 1); ei.cyc = c;
              if (reset_at < 0 || c <= reset_at) expI.push_back(ei);
              if (k == E - 1) begin
                ew.sel = 2'(m); ew.a = XW'(tk * E + d); ew.cyc = c + MAC_LAT;
                if (reset_at < 0 || ew.cyc <= reset_at) expW.push_back(ew);
              end
              last_c = c;
              c++;
            end
      end
    end
    exp_done = (m_cnt == 0) ? 2 : last_c + MAC_LAT + 1;
    rst_rel  = -1;
    if (reset_at >= 0) begin
      exp_done = -1;
      rst_rel  = reset_at;
    end

    @(posedge clk); #1;
    t0 = cyc;
    got_done = 1'b0;
    active = 1'b1;
    bus.start = 1'b1;
    bus.mat_en = men;
    bus.stall = stall_pat[0];
    forever begin
      @(posedge clk); #1;
      rel = cyc - t0;
      bus.start  = (rel == restart_at);
      bus.mat_en = 3'($urandom);
      bus.stall  = (rel < MAXC) ? stall_pat[rel] : 1'b0;
      rst        = (rel == reset_at);
      if (exp_done >= 0 && rel > exp_done + 3) break;
      if (exp_done < 0 && rel > reset_at + 10) break;
      if (rel > MAXC - 10) break;
    end
    active = 1'b0;
    rst = 1'b0;
    bus.start = 1'b0;
    bus.stall = 1'b0;
    check("issues_left", 64'(expI.size()), 64'(0));
    check("writes_left", 64'(expW.size()), 64'(0));
    check("done_seen", 64'(got_done), 64'(exp_done >= 0));
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.mat_en = '0;
    bus.stall = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state",
          64'({bus.busy, bus.done, bus.mac_valid, bus.mac_first, bus.mac_last, bus.w_sel,
               bus.x_addr, bus.w_addr, bus.wr_en, bus.wr_sel, bus.wr_addr}), 64'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    run(3'b111, 0, -1, -1, -1, -1);   // full run, done at 1540
    run(3'b010, 0, -1, -1, -1, -1);   // K only, done at 516
    run(3'b000, 0, -1, -1, -1, -1);   // empty mask, done at 2
    run(3'b001, 0, 5, 14, -1, -1);    // ten stalls, done at 526
    run(3'b111, 0, -1, -1, -1, 200);  // reset mid-run
    run(3'b111, 0, -1, -1, -1, -1);   // restart after reset, done at 1540 relative
    run(3'b111, 0, -1, -1, 50, -1);   // second start ignored
    for (int i = 0; i < 4; i++)
      run(3'($urandom_range(7)), 20, -1, -1, $urandom_range(300), -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
